// File: rtl/sekiz_kanal_hakem.sv
// sekiz_kanal_hakem: round-robin arbiter and sequencer for the 8:1 x WIDTH result mux tree.
//
// Eight requesters share one mux tree. Channel i sits on mux input A0,B0,A1,B1,A2,B2,A3,B3
// (i = 0..7), so the mux selects are simply {en3,en2,en1} = i. The winning channel's word is
// captured from z_in after a one-cycle settle and offered on a valid/ready port. Each granted
// requester may take up to BURST_MAX consecutive transfers before the pointer moves on.
//
// Parameters:
//   WIDTH      data width of z_in / out_data
//   BURST_MAX  consecutive transfers per grant before the pointer advances (1..15)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous reset, active-low
//   req[7:0]   level request per channel
//   gnt[7:0]   one-hot grant, held from arbitration until the channel's last transfer
//   en1/2/3    mux selects, {en3,en2,en1} = granted index; hold their value while idle
//   z_in       mux tree output
//   out_data   captured word
//   out_src    channel index of out_data
//   out_valid  out_data valid
//   out_ready  consumer accept; a transfer is out_valid & out_ready at the clock edge
//   busy       high whenever the sequencer is not idle
//
// Build option:
//   SEKIZ_HAKEM_PRIO0_EN  channel 0 becomes urgent: it wins every arbitration it requests in.
//                         A grant won only through this override leaves the pointer unchanged.

module sekiz_kanal_hakem #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BURST_MAX = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    output logic [7:0]       gnt,
    output logic             en1,
    output logic             en2,
    output logic             en3,
    input  logic [WIDTH-1:0] z_in,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StSel,
        StOut
    } state_e;

    state_e     state;
    logic [2:0] ptr;
    logic [2:0] idx;
    logic [3:0] burst_cnt;

    logic [2:0] ptr_next;
    logic [2:0] arb_base;
    logic [2:0] arb_idx;
    logic       burst_more;

`ifdef SEKIZ_HAKEM_PRIO0_EN
    logic       prio_win;
    logic       arb_override;
`endif

    // First requesting channel at or after base, scanning circularly. Iterating from the far
    // end down means the closest hit is the last assignment and therefore wins.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [2:0] c;
        rr_pick = base;
        for (int i = 7; i >= 0; i--) begin
            c = base + 3'(i);
            if (r[c]) begin
                rr_pick = c;
            end
        end
    endfunction

    // Pointer value once the current grant retires.
    always_comb begin
        ptr_next = idx + 3'd1;
`ifdef SEKIZ_HAKEM_PRIO0_EN
        if (prio_win) begin
            ptr_next = ptr;
        end
`endif
    end

    // Re-arbitration out of OUT happens in the same edge that retires the grant, so it has to
    // scan from the pointer value being written, not the stale one.
    assign arb_base = (state == StOut) ? ptr_next : ptr;

`ifdef SEKIZ_HAKEM_PRIO0_EN
    always_comb begin
        arb_override = 1'b0;
        arb_idx      = rr_pick(req, arb_base);
        if (req[0]) begin
            // Only an override if round-robin alone would not have chosen channel 0.
            arb_override = (arb_idx != 3'd0);
            arb_idx      = 3'd0;
        end
    end
`else
    assign arb_idx = rr_pick(req, arb_base);
`endif

    // Another transfer for the same requester is allowed while it still asks and the burst
    // budget (counting the transfer now completing) is not spent.
    assign burst_more = req[idx] && (({1'b0, burst_cnt} + 5'd1) < 5'(BURST_MAX));

    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            ptr       <= 3'd0;
            idx       <= 3'd0;
            burst_cnt <= 4'd0;
            gnt       <= 8'd0;
            en1       <= 1'b0;
            en2       <= 1'b0;
            en3       <= 1'b0;
            out_data  <= '0;
            out_src   <= 3'd0;
            out_valid <= 1'b0;
`ifdef SEKIZ_HAKEM_PRIO0_EN
            prio_win  <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (|req) begin
                        idx             <= arb_idx;
                        gnt             <= 8'd1 << arb_idx;
                        {en3, en2, en1} <= arb_idx;
`ifdef SEKIZ_HAKEM_PRIO0_EN
                        prio_win        <= arb_override;
`endif
                        state           <= StSel;
                    end
                end

                // Selects were registered last edge; the mux output has now settled.
                StSel: begin
                    out_data  <= z_in;
                    out_src   <= idx;
                    out_valid <= 1'b1;
                    state     <= StOut;
                end

                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (burst_more) begin
                            burst_cnt <= burst_cnt + 4'd1;
                            state     <= StSel;
                        end else begin
                            burst_cnt <= 4'd0;
                            ptr       <= ptr_next;
                            if (|req) begin
                                idx             <= arb_idx;
                                gnt             <= 8'd1 << arb_idx;
                                {en3, en2, en1} <= arb_idx;
`ifdef SEKIZ_HAKEM_PRIO0_EN
                                prio_win        <= arb_override;
`endif
                                state           <= StSel;
                            end else begin
                                // en* deliberately keep the last select while idle.
                                gnt   <= 8'd0;
                                state <= StIdle;
                            end
                        end
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
